mem_arbiter: RTL and testbench

//  Shares the single unified byte-addressed memory between the instruction-fetch

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_wait_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_defs: encodings and arbitration helper shared by mem_arbiter and its bench-facing
// sub-blocks.
//   state_e  : ST_IDLE / ST_ACCESS / ST_RESP   sequencer states
//   owner_e  : OWN_I (fetch port) / OWN_D (load/store port)
//   pick_owner(): round-robin choice between the two request lines
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // With both ports requesting, the port that did not win last time goes next.
  // Only meaningful when at least one request is high.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                        input owner_e last_grant);
    if (i_req && d_req) return (last_grant == OWN_I) ? OWN_D : OWN_I;
    else if (d_req)     return OWN_D;
    else                return OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_ctr.sv
// mem_wait_ctr: wait-state down-counter for the memory access sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : wait-state count to start from
//   dec        : count down by one; holds at zero
//   zero       : counter is zero
module mem_wait_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (load)                   cnt <= load_val;
    else if (dec && (cnt != '0))     cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed memory between the instruction-fetch
// port (I, read-only) and the load/store port (D). Each granted access spends
// WAIT_CYCLES+1 cycles in ACCESS (memory edge on the last one), then one RESP
// cycle that pulses the owner's ack.
//   I port : i_req, i_adr -> i_rdata, i_ack
//   D port : d_req, d_we, d_adr, d_wdata -> d_rdata (0 for stores), d_ack
//   status : err (misaligned access, with the ack), busy (not IDLE)
//   memory : mem_adr, mem_din, mem_rd, mem_wr -> mem_dout (combinational read)
// Build option: define MEM_ALIGN_CHK_EN to reject accesses with adr[1:0] != 0
// (no memory cycle, rdata = 0, err = 1 with the ack). Undefined: err is 0 and
// misaligned addresses go to memory unchanged.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e            state, state_nx;
  owner_e            owner, last_grant, gnt_owner;
  logic [ADDR_W-1:0] adr_q, gnt_adr;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, misal_q;
  logic              grant, gnt_misal, cnt_zero;

  // ---------------- grant decode (only acted on in IDLE) ----------------
  assign grant     = (state == ST_IDLE) && (i_req || d_req);
  assign gnt_owner = pick_owner(i_req, d_req, last_grant);
  assign gnt_adr   = (gnt_owner == OWN_D) ? d_adr : i_adr;

`ifdef MEM_ALIGN_CHK_EN
  assign gnt_misal = (gnt_adr[1:0] != 2'b00);
`else
  assign gnt_misal = 1'b0;
`endif

  mem_wait_ctr #(.CNT_W(CNT_W)) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant),
    .load_val (WAIT_LD),
    .dec      (state == ST_ACCESS),
    .zero     (cnt_zero)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (grant) state_nx = gnt_misal ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt_zero) state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;   // req is not looked at here
      default:   state_nx = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Derived from the asynchronously reset state, so mem_wr drops the moment
  // rst_n falls and an interrupted store never reaches memory.
  always_comb begin
    busy    = (state != ST_IDLE);
    mem_adr = '0;
    mem_din = '0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    err     = 1'b0;
    case (state)
      ST_ACCESS: begin
        mem_adr = adr_q;
        mem_din = wdata_q;
        mem_rd  = ~we_q;
        mem_wr  = we_q & cnt_zero;   // single write edge at the end of ACCESS
      end
      ST_RESP: begin
        i_ack = (owner == OWN_I);
        d_ack = (owner == OWN_D);
        err   = misal_q;
      end
      default: ;
    endcase
  end

  // ---------------- request latch and read-data capture ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      misal_q    <= 1'b0;
      owner      <= OWN_I;
      last_grant <= OWN_D;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else if (grant) begin
      adr_q      <= gnt_adr;
      wdata_q    <= (gnt_owner == OWN_D) ? d_wdata : '0;
      we_q       <= (gnt_owner == OWN_D) && d_we;   // the fetch port never writes
      misal_q    <= gnt_misal;
      owner      <= gnt_owner;
      last_grant <= gnt_owner;
      // A rejected access still completes, returning zero data.
      if (gnt_misal) begin
        if (gnt_owner == OWN_I) i_rdata <= '0;
        else                    d_rdata <= '0;
      end
    end else if ((state == ST_ACCESS) && cnt_zero) begin
      if (owner == OWN_I) i_rdata <= mem_dout;
      else                d_rdata <= we_q ? '0 : mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Main instance runs WAIT_CYCLES=1 against
// a word memory model; two extra instances (WAIT_CYCLES=0 and 3) are used for
// latency only. Expected values come from a transaction-level reference model:
// a reference memory array, the round-robin rule and the latency formulas.
module tb_mem_arbiter;

  localparam int WAIT = 1;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_adr, d_adr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_adr, mem_din, mem_dout;
  logic        i_ack, d_ack, err, busy, mem_rd, mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .busy(busy),
    .mem_adr(mem_adr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout)
  );

  // ---------------- latency-only instances: WAIT_CYCLES 0 and 3 ----------------
  logic [1:0]  wx_i_req = 2'b00;
  logic [31:0] wx_i_adr = 32'h0000_0040;
  logic [1:0]  wx_i_ack, wx_d_ack, wx_err, wx_busy, wx_mem_rd, wx_mem_wr;
  logic [31:0] wx_i_rdata [2];
  logic [31:0] wx_d_rdata [2];
  logic [31:0] wx_mem_adr [2];
  logic [31:0] wx_mem_din [2];

  mem_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(wx_i_req[0]), .i_adr(wx_i_adr), .i_rdata(wx_i_rdata[0]), .i_ack(wx_i_ack[0]),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'h0), .d_wdata(32'h0),
    .d_rdata(wx_d_rdata[0]), .d_ack(wx_d_ack[0]), .err(wx_err[0]), .busy(wx_busy[0]),
    .mem_adr(wx_mem_adr[0]), .mem_din(wx_mem_din[0]), .mem_rd(wx_mem_rd[0]),
    .mem_wr(wx_mem_wr[0]), .mem_dout(~wx_mem_adr[0])
  );

  mem_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(wx_i_req[1]), .i_adr(wx_i_adr), .i_rdata(wx_i_rdata[1]), .i_ack(wx_i_ack[1]),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'h0), .d_wdata(32'h0),
    .d_rdata(wx_d_rdata[1]), .d_ack(wx_d_ack[1]), .err(wx_err[1]), .busy(wx_busy[1]),
    .mem_adr(wx_mem_adr[1]), .mem_din(wx_mem_din[1]), .mem_rd(wx_mem_rd[1]),
    .mem_wr(wx_mem_wr[1]), .mem_dout(~wx_mem_adr[1])
  );

  // ---------------- memory attached to the main instance (4 KB window) ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h2002_0004 : ((i * 32'h9E37_79B9) ^ 32'h5A5A_0000);
  endfunction

  logic [31:0] mem [1024];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_adr[11:2]] <= mem_din;
    end
  end

  assign mem_dout = mem[mem_adr[11:2]];

  // Cycles with read/write enable high, counted away from the active edge.
  int wr_cycles = 0;
  int rd_cycles = 0;
  always @(negedge clk) begin
    if (mem_wr === 1'b1) wr_cycles <= wr_cycles + 1;
    if (mem_rd === 1'b1) rd_cycles <= rd_cycles + 1;
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [1024];
  bit          last_d = 1'b1;          // previous winner was the D port
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a);
    return ALIGN_EN && (a[1:0] != 2'b00);
  endfunction

  // Raise the requested port(s) and follow them to completion, checking each ack.
  task automatic issue(input bit ri, input bit rd, input logic [31:0] ia,
                       input logic [31:0] da, input bit we, input logic [31:0] wd,
                       input string tag);
    int          n, cyc, lat, wr0, rd0, exp_wr, exp_rd;
    bit          first_d, is_d, wr, mis;
    logic [31:0] adr;
    exp_wr = 0;
    exp_rd = 0;
    @(negedge clk);
    wr0 = wr_cycles;
    rd0 = rd_cycles;
    i_req = ri; i_adr = ia;
    d_req = rd; d_we = we; d_adr = da; d_wdata = wd;
    n       = int'(ri) + int'(rd);
    first_d = (ri && rd) ? !last_d : rd;
    for (int s = 0; s < n; s++) begin
      is_d = (s == 0) ? first_d : !first_d;
      adr  = is_d ? da : ia;
      wr   = is_d && we;
      mis  = misal(adr);
      lat  = (mis ? 1 : WAIT + 2) + ((s == 0) ? 0 : 1);
      cyc  = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!mis && cyc == ((s == 0) ? 1 : 2)) begin
          check({tag, "_mem_adr"}, mem_adr, adr);
          check({tag, "_mem_rd"}, {31'b0, mem_rd}, {31'b0, !wr});
        end
      end while (!(i_ack === 1'b1 || d_ack === 1'b1) && cyc < 20);
      // Reference outcome of this transaction.
      if (is_d) begin
        exp_d_rdata = (mis || wr) ? 32'h0 : ref_mem[adr[11:2]];
        if (wr && !mis) ref_mem[adr[11:2]] = wd;
      end else begin
        exp_i_rdata = mis ? 32'h0 : ref_mem[adr[11:2]];
      end
      if (!mis) begin
        if (wr) exp_wr++;
        else    exp_rd += WAIT + 1;
      end
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_i_ack"}, {31'b0, i_ack}, {31'b0, !is_d});
      check({tag, "_d_ack"}, {31'b0, d_ack}, {31'b0, is_d});
      check({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
      check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
      check({tag, "_err"}, {31'b0, err}, {31'b0, mis});
      check({tag, "_resp_mem_wr"}, {31'b0, mem_wr}, 32'h0);
      last_d = is_d;
      if (is_d) d_req = 1'b0;
      else      i_req = 1'b0;
    end
    @(negedge clk);
    check({tag, "_busy_idle"}, {31'b0, busy}, 32'h0);
    check({tag, "_wr_cycles"}, wr_cycles - wr0, exp_wr);
    check({tag, "_rd_cycles"}, rd_cycles - rd0, exp_rd);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int          cyc;
    int          kind;
    logic [31:0] ra, rb;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    i_req = 1'b0; i_adr = '0;
    d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",    {31'b0, busy},   32'h0);
    check("rst_i_ack",   {31'b0, i_ack},  32'h0);
    check("rst_d_ack",   {31'b0, d_ack},  32'h0);
    check("rst_err",     {31'b0, err},    32'h0);
    check("rst_i_rdata", i_rdata,         32'h0);
    check("rst_d_rdata", d_rdata,         32'h0);
    check("rst_mem_adr", mem_adr,         32'h0);
    check("rst_mem_din", mem_din,         32'h0);
    check("rst_mem_rdwr", {30'b0, mem_rd, mem_wr}, 32'h0);
    rst_n = 1'b1;

    // Fetch of word 0
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "fetch0");
    check("fetch0_word", i_rdata, 32'h2002_0004);

    // Store then load at 1000
    issue(1'b0, 1'b1, 32'h0, 32'd1000, 1'b1, 32'hDEAD_BEEF, "store1000");
    issue(1'b0, 1'b1, 32'h0, 32'd1000, 1'b0, 32'h0, "load1000");
    check("load1000_word", d_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: round-robin order
    issue(1'b1, 1'b1, 32'h10, 32'h20, 1'b0, 32'h0, "both_a");
    issue(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, "fetch_only");
    issue(1'b1, 1'b1, 32'h40, 32'h44, 1'b1, 32'h1234_5678, "both_b");

    // Misaligned load
    issue(1'b0, 1'b1, 32'h0, 32'd1002, 1'b0, 32'h0, "mis1002");

    // Wait-state latency on the WAIT_CYCLES=0 and 3 instances
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wx_i_req[k] = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (wx_i_ack[k] !== 1'b1 && cyc < 20);
      check((k == 0) ? "w0_latency" : "w3_latency", cyc, (k == 0) ? 2 : 5);
      check((k == 0) ? "w0_rdata" : "w3_rdata", wx_i_rdata[k], ~32'h0000_0040);
      wx_i_req[k] = 1'b0;
    end

    // Randomized mix of fetches, loads, stores and collisions
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      ra   = $urandom & 32'hFFFF_FFFC;
      rb   = $urandom & 32'hFFFF_FFFC;
      issue(kind != 1, kind != 0, ra, rb, 1'($urandom), $urandom, "rand");
    end

    // Reset during the write cycle of a store to 2000
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'd2000; d_wdata = 32'hCAFE_F00D;
    repeat (WAIT + 1) @(negedge clk);
    check("rst_pre_mem_wr", {31'b0, mem_wr}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_cut_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_cut_busy",   {31'b0, busy},   32'h0);
    check("rst_cut_d_ack",  {31'b0, d_ack},  32'h0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_d = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_cut_mem2000", mem[500], ref_mem[500]);
    check("rst_cut_no_ack",  {30'b0, i_ack, d_ack}, 32'h0);
    issue(1'b1, 1'b1, 32'h0, 32'd2000, 1'b0, 32'h0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
